rc4_crack_core: RTL and testbench

//  Parametrised RC4 decrypt engine that runs S-box init, key scheduling and PRGA/XOR as one FSM.
//  It owns the port of the external S RAM, the encrypted-message ROM and the decrypted-message RAM.

---
 rtl/rc4_crack_core.sv | 201 ++++++++++++++++++++
 tb/tb_rc4_crack_core.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_crack_core.sv
// RC4 decrypt engine: S-box init, key scheduling and keystream/XOR, run as one FSM.
// It owns the ports of the external S RAM, the ciphertext ROM and the plaintext RAM.
// Optionally stops at the first byte that is not a lowercase letter or a space.
module rc4_crack_core #(
  parameter int KEY_BYTES = 3,
  parameter int MSG_LEN   = 32,
  parameter int MSG_AW    = 5,
  parameter int CHECK_EN  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [7:0]             s_addr,
  output logic [7:0]             s_wrdata,
  output logic                   s_wren,
  input  logic [7:0]             s_rddata,
  output logic [MSG_AW-1:0]      enc_addr,
  input  logic [7:0]             enc_rddata,
  output logic [MSG_AW-1:0]      dec_addr,
  output logic [7:0]             dec_wrdata,
  output logic                   dec_wren
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_KSA, S_PRGA, S_DONE} state_t;

  localparam logic [MSG_AW:0] LastK = (MSG_AW + 1)'(MSG_LEN - 1);

  state_t                 state_q;
  logic [3:0]             phase_q;
  logic [7:0]             i_q, j_q, si_q, sj_q;
  logic [MSG_AW:0]        k_q;
  logic [8*KEY_BYTES-1:0] keyrot_q;
  logic                   busy_q, done_q, pass_q;
  logic [7:0]             s_addr_q, s_wrdata_q;
  logic                   s_wren_q;
  logic [MSG_AW-1:0]      enc_addr_q, dec_addr_q;
  logic [7:0]             dec_wrdata_q;
  logic                   dec_wren_q;

  logic [7:0] key_byte_d, j_d, plain_d;
  logic       reject_d;

  // Shared datapath: next j for both schedules, and the plaintext byte with its check.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch can be inferred.
    key_byte_d = keyrot_q[8*KEY_BYTES-1 -: 8];
    j_d        = j_q + s_rddata + ((state_q == S_KSA) ? key_byte_d : 8'd0);
    plain_d    = s_rddata ^ enc_rddata;
    reject_d   = (CHECK_EN != 0) &&
                 !(((plain_d >= 8'h61) && (plain_d <= 8'h7A)) || (plain_d == 8'h20));
  end

  // Main FSM; every port is driven from a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      i_q          <= '0;
      j_q          <= '0;
      si_q         <= '0;
      sj_q         <= '0;
      k_q          <= '0;
      keyrot_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      s_addr_q     <= '0;
      s_wrdata_q   <= '0;
      s_wren_q     <= 1'b0;
      enc_addr_q   <= '0;
      dec_addr_q   <= '0;
      dec_wrdata_q <= '0;
      dec_wren_q   <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every branch sees
      // the values from the start of the cycle, independent of statement order.
      s_wren_q   <= 1'b0;
      dec_wren_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (busy_q) begin
            // Last plaintext write has been presented; now report completion.
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else if (start) begin
            state_q  <= S_INIT;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            keyrot_q <= key;
            i_q      <= '0;
          end
        end
        S_INIT: begin
          s_addr_q   <= i_q;
          s_wrdata_q <= i_q;
          s_wren_q   <= 1'b1;
          i_q        <= i_q + 8'd1;
          if (i_q == 8'hFF) begin
            state_q <= S_KSA;
            phase_q <= '0;
            j_q     <= '0;
          end
        end
        S_KSA: begin
          phase_q <= (phase_q == 4'd5) ? 4'd0 : phase_q + 4'd1;
          case (phase_q)
            4'd0: s_addr_q <= i_q;
            4'd2: begin
              si_q     <= s_rddata;
              j_q      <= j_d;
              s_addr_q <= j_d;
              // Rotating the key one byte per i yields key[i % KEY_BYTES] MSB-first.
              keyrot_q <= (keyrot_q << 8) | (keyrot_q >> (8*KEY_BYTES - 8));
            end
            4'd4: begin
              sj_q       <= s_rddata;
              s_addr_q   <= i_q;
              s_wrdata_q <= s_rddata;
              s_wren_q   <= 1'b1;
            end
            4'd5: begin
              s_addr_q   <= j_q;
              s_wrdata_q <= si_q;
              s_wren_q   <= 1'b1;
              i_q        <= i_q + 8'd1;
              if (i_q == 8'hFF) begin
                state_q <= S_PRGA;
                i_q     <= '0;
                j_q     <= '0;
                k_q     <= '0;
              end
            end
            default: ;
          endcase
        end
        S_PRGA: begin
          phase_q <= (phase_q == 4'd8) ? 4'd0 : phase_q + 4'd1;
          case (phase_q)
            4'd0: begin
              i_q      <= i_q + 8'd1;
              s_addr_q <= i_q + 8'd1;
            end
            4'd2: begin
              si_q     <= s_rddata;
              j_q      <= j_d;
              s_addr_q <= j_d;
            end
            4'd4: begin
              sj_q       <= s_rddata;
              s_addr_q   <= i_q;
              s_wrdata_q <= s_rddata;
              s_wren_q   <= 1'b1;
            end
            4'd5: begin
              s_addr_q   <= j_q;
              s_wrdata_q <= si_q;
              s_wren_q   <= 1'b1;
            end
            4'd6: begin
              s_addr_q   <= si_q + sj_q;
              enc_addr_q <= k_q[MSG_AW-1:0];
            end
            4'd8: begin
              // The byte is written even when it fails the check.
              dec_addr_q   <= k_q[MSG_AW-1:0];
              dec_wrdata_q <= plain_d;
              dec_wren_q   <= 1'b1;
              k_q          <= k_q + 1'b1;
              if (reject_d) begin
                state_q <= S_DONE;
                pass_q  <= 1'b0;
              end else if (k_q == LastK) begin
                state_q <= S_DONE;
                pass_q  <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign s_addr     = s_addr_q;
  assign s_wrdata   = s_wrdata_q;
  assign s_wren     = s_wren_q;
  assign enc_addr   = enc_addr_q;
  assign dec_addr   = dec_addr_q;
  assign dec_wrdata = dec_wrdata_q;
  assign dec_wren   = dec_wren_q;

endmodule

// File: tb/tb_rc4_crack_core.sv
// Bench for rc4_crack_core: three instances (plain, checked, 4-byte key) with memory
// models, a plain RC4 reference, and a per-cycle compare/monitor process.
module tb_rc4_crack_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_w    [3];
  logic [31:0] key_w      [3];
  logic        busy_w     [3];
  logic        done_w     [3];
  logic        pass_w     [3];
  logic [7:0]  s_addr_w   [3];
  logic [7:0]  s_wrdata_w [3];
  logic        s_wren_w   [3];
  logic [7:0]  s_rd       [3];
  logic [4:0]  enc_addr_w [3];
  logic [7:0]  enc_rd     [3];
  logic [4:0]  dec_addr_w [3];
  logic [7:0]  dec_wrdata_w [3];
  logic        dec_wren_w [3];

  logic [7:0]  s_mem   [3][256];
  logic [7:0]  enc_mem [3][32];
  logic [7:0]  dec_mem [3][32];

  logic [7:0]  m_dec  [3][32];
  int          m_n    [3];
  bit          m_pass [3];

  int n_tests = 0;
  int n_fail  = 0;
  int last_lat [3];

  always #5 clk = ~clk;

  rc4_crack_core #(.KEY_BYTES(3), .MSG_LEN(9), .MSG_AW(5), .CHECK_EN(0)) dut_a (
    .clk(clk), .reset(reset), .start(start_w[0]), .key(key_w[0][23:0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .s_addr(s_addr_w[0]), .s_wrdata(s_wrdata_w[0]), .s_wren(s_wren_w[0]), .s_rddata(s_rd[0]),
    .enc_addr(enc_addr_w[0]), .enc_rddata(enc_rd[0]),
    .dec_addr(dec_addr_w[0]), .dec_wrdata(dec_wrdata_w[0]), .dec_wren(dec_wren_w[0]));

  rc4_crack_core #(.KEY_BYTES(3), .MSG_LEN(9), .MSG_AW(5), .CHECK_EN(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_w[1]), .key(key_w[1][23:0]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .s_addr(s_addr_w[1]), .s_wrdata(s_wrdata_w[1]), .s_wren(s_wren_w[1]), .s_rddata(s_rd[1]),
    .enc_addr(enc_addr_w[1]), .enc_rddata(enc_rd[1]),
    .dec_addr(dec_addr_w[1]), .dec_wrdata(dec_wrdata_w[1]), .dec_wren(dec_wren_w[1]));

  rc4_crack_core #(.KEY_BYTES(4), .MSG_LEN(5), .MSG_AW(5), .CHECK_EN(1)) dut_c (
    .clk(clk), .reset(reset), .start(start_w[2]), .key(key_w[2]),
    .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
    .s_addr(s_addr_w[2]), .s_wrdata(s_wrdata_w[2]), .s_wren(s_wren_w[2]), .s_rddata(s_rd[2]),
    .enc_addr(enc_addr_w[2]), .enc_rddata(enc_rd[2]),
    .dec_addr(dec_addr_w[2]), .dec_wrdata(dec_wrdata_w[2]), .dec_wren(dec_wren_w[2]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference RC4 written straight from the algorithm, on a plain array.
  task automatic model(input int d, input logic [31:0] k, input int kb, input int len, input bit chk);
    logic [7:0] s [256];
    logic [7:0] tmp, kbyte, o;
    int i, j;
    for (int x = 0; x < 256; x++) s[x] = x[7:0];
    j = 0;
    for (int x = 0; x < 256; x++) begin
      kbyte = 8'(k >> (8 * (kb - 1 - (x % kb))));
      j = (j + s[x] + kbyte) % 256;
      tmp = s[x]; s[x] = s[j]; s[j] = tmp;
    end
    i = 0; j = 0; m_pass[d] = 1'b1; m_n[d] = 0;
    for (int n = 0; n < len; n++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      tmp = s[i]; s[i] = s[j]; s[j] = tmp;
      o = s[(s[i] + s[j]) % 256] ^ enc_mem[d][n];
      m_dec[d][n] = o;
      m_n[d] = n + 1;
      if (chk && !(((o >= 8'h61) && (o <= 8'h7A)) || (o == 8'h20))) begin
        m_pass[d] = 1'b0;
        break;
      end
    end
  endtask

  // Single-port S RAM, ciphertext ROM and plaintext RAM, each with a registered read.
  task automatic mem_loop();
    forever begin
      @(posedge clk);
      for (int d = 0; d < 3; d++) begin
        if (s_wren_w[d]) s_mem[d][s_addr_w[d]] <= s_wrdata_w[d];
        s_rd[d]   <= s_mem[d][s_addr_w[d]];
        enc_rd[d] <= enc_mem[d][enc_addr_w[d]];
        if (dec_wren_w[d]) dec_mem[d][dec_addr_w[d]] <= dec_wrdata_w[d];
      end
    end
  endtask

  // Per-cycle comparison of every instance against the reference results.
  task automatic cmp_loop();
    bit prev_busy [3];
    bit prev_done [3];
    bit running   [3];
    int lat       [3];
    int wr_cnt    [3];
    int viol      [3];
    for (int d = 0; d < 3; d++) begin
      prev_busy[d] = 0; prev_done[d] = 0; running[d] = 0;
      lat[d] = 0; wr_cnt[d] = 0; viol[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (reset) begin
          running[d] = 0;
        end else begin
          if (busy_w[d] && !prev_busy[d]) begin
            lat[d] = 0; wr_cnt[d] = 0; running[d] = 1;
          end else begin
            lat[d]++;
          end
          if (s_wren_w[d] && dec_wren_w[d]) viol[d]++;
          if (!busy_w[d] && (s_wren_w[d] || dec_wren_w[d])) viol[d]++;
          if (running[d] && lat[d] >= 1 && lat[d] <= 256) begin
            if (!s_wren_w[d] || s_addr_w[d] != 8'(lat[d] - 1) || s_wrdata_w[d] != 8'(lat[d] - 1))
              viol[d]++;
          end
          if (dec_wren_w[d]) begin
            check($sformatf("dut%0d dec_addr", d), 64'(dec_addr_w[d]), 64'(wr_cnt[d]));
            if (wr_cnt[d] < m_n[d])
              check($sformatf("dut%0d dec_data[%0d]", d, wr_cnt[d]), 64'(dec_wrdata_w[d]), 64'(m_dec[d][wr_cnt[d]]));
            else
              check($sformatf("dut%0d extra dec write", d), 64'(wr_cnt[d]), 64'(m_n[d] - 1));
            wr_cnt[d]++;
          end
          if (done_w[d] && !prev_done[d] && running[d]) begin
            check($sformatf("dut%0d latency", d), 64'(lat[d]), 64'(1793 + 9 * m_n[d]));
            check($sformatf("dut%0d write count", d), 64'(wr_cnt[d]), 64'(m_n[d]));
            check($sformatf("dut%0d pass", d), 64'(pass_w[d]), 64'(m_pass[d]));
            check($sformatf("dut%0d port rules", d), 64'(viol[d]), 64'd0);
            last_lat[d] = lat[d];
            running[d]  = 0;
          end
        end
        prev_busy[d] = busy_w[d];
        prev_done[d] = done_w[d];
      end
    end
  endtask

  task automatic check_idle(input int d, input string tag);
    check({tag, " ctrl"}, {busy_w[d], done_w[d], pass_w[d], s_wren_w[d], dec_wren_w[d]}, 64'd0);
    check({tag, " data"}, {s_addr_w[d], s_wrdata_w[d], enc_addr_w[d], dec_addr_w[d], dec_wrdata_w[d]}, 64'd0);
  endtask

  task automatic wait_done(input int d);
    int n = 0;
    while (!done_w[d] && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("dut%0d done within budget", d), 64'(done_w[d]), 64'd1);
  endtask

  task automatic run(input int d);
    start_w[d] = 1'b1;
    @(negedge clk);
    start_w[d] = 1'b0;
    wait_done(d);
    @(negedge clk);
  endtask

  task automatic prep(input int d);
    for (int x = 0; x < 256; x++) s_mem[d][x] = 8'($urandom);
    for (int x = 0; x < 32; x++) dec_mem[d][x] = 8'h00;
  endtask

  initial begin
    logic [7:0] ct1 [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic [7:0] ct3 [5] = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
    string pt1 = "Plaintext";
    string pt3 = "pedia";

    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      start_w[d] = 1'b0;
      for (int x = 0; x < 32; x++) enc_mem[d][x] = 8'h00;
      prep(d);
    end
    for (int x = 0; x < 9; x++) begin
      enc_mem[0][x] = ct1[x];
      enc_mem[1][x] = ct1[x];
    end
    for (int x = 0; x < 5; x++) enc_mem[2][x] = ct3[x];
    key_w[0] = 32'h004B6579;
    key_w[1] = 32'h004B6579;
    key_w[2] = 32'h57696B69;

    fork
      mem_loop();
      cmp_loop();
    join_none

    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) check_idle(d, $sformatf("dut%0d reset", d));
    reset = 1'b0;
    @(negedge clk);

    // Reference pinned to the known RC4 vectors.
    model(0, key_w[0], 3, 9, 1'b0);
    model(1, key_w[1], 3, 9, 1'b1);
    model(2, key_w[2], 4, 5, 1'b1);
    check("model1 length", 64'(m_n[0]), 64'd9);
    check("model1 pass", 64'(m_pass[0]), 64'd1);
    for (int x = 0; x < 9; x++) check($sformatf("model1 byte %0d", x), 64'(m_dec[0][x]), 64'(pt1[x]));
    check("model2 length", 64'(m_n[1]), 64'd1);
    check("model2 pass", 64'(m_pass[1]), 64'd0);
    for (int x = 0; x < 5; x++) check($sformatf("model3 byte %0d", x), 64'(m_dec[2][x]), 64'(pt3[x]));

    // Test 1: unchecked decrypt of "Plaintext".
    run(0);
    for (int x = 0; x < 9; x++) check($sformatf("t1 ram %0d", x), 64'(dec_mem[0][x]), 64'(pt1[x]));
    check("t1 pass", 64'(pass_w[0]), 64'd1);
    check("t1 latency", 64'(last_lat[0]), 64'd1874);

    // Test 2: checked run aborts on 'P'.
    run(1);
    check("t2 ram 0", 64'(dec_mem[1][0]), 64'h50);
    check("t2 ram 1 untouched", 64'(dec_mem[1][1]), 64'h00);
    check("t2 pass", 64'(pass_w[1]), 64'd0);
    check("t2 latency", 64'(last_lat[1]), 64'd1802);

    // Test 3: 4-byte key, checked, "pedia".
    run(2);
    for (int x = 0; x < 5; x++) check($sformatf("t3 ram %0d", x), 64'(dec_mem[2][x]), 64'(pt3[x]));
    check("t3 pass", 64'(pass_w[2]), 64'd1);
    check("t3 latency", 64'(last_lat[2]), 64'd1838);

    // Test 4: reset during KSA, then identical rerun.
    prep(0);
    start_w[0] = 1'b1;
    @(negedge clk);
    start_w[0] = 1'b0;
    repeat (256 + 600) @(negedge clk);
    check("t4 busy before reset", 64'(busy_w[0]), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle(0, "t4 after reset");
    @(negedge clk);
    prep(0);
    run(0);
    for (int x = 0; x < 9; x++) check($sformatf("t4 ram %0d", x), 64'(dec_mem[0][x]), 64'(pt1[x]));
    check("t4 pass", 64'(pass_w[0]), 64'd1);
    check("t4 latency", 64'(last_lat[0]), 64'd1874);

    // Test 5: start held high throughout; immediate restart from DONE.
    prep(0);
    start_w[0] = 1'b1;
    @(negedge clk);
    wait_done(0);
    check("t5 busy low at done", 64'(busy_w[0]), 64'd0);
    check("t5 pass", 64'(pass_w[0]), 64'd1);
    @(negedge clk);
    check("t5 restart done", 64'(done_w[0]), 64'd0);
    check("t5 restart busy", 64'(busy_w[0]), 64'd1);
    start_w[0] = 1'b0;
    wait_done(0);
    @(negedge clk);
    for (int x = 0; x < 9; x++) check($sformatf("t5 ram %0d", x), 64'(dec_mem[0][x]), 64'(pt1[x]));
    check("t5 latency", 64'(last_lat[0]), 64'd1874);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
